clk_switch_ctrl: RTL and testbench



---
 rtl/clk_switch_ctrl.sv | 170 +++++++++++++++++
 tb/tb_clk_switch_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_switch_ctrl.sv
// -----------------------------------------------------------------------------
// clk_switch_ctrl
//
// Sequencing controller for the glitch-free clock switch. It produces the
// switch's `sel` input, choosing clk0 (always-on reference) or clk1 (PLL
// output). Switch requests arrive over a valid/ready handshake. clk1 is only
// selected after the PLL lock indication has been high for LOCK_FILTER
// consecutive synchronized cycles. After every change of `sel` the value is
// held for SETTLE_CYCLES cycles so the switch's internal handshake can finish.
// If lock drops while clk1 is selected, the block falls back to clk0 on its
// own. The block runs on the always-on reference clock.
//
// Ports:
//   clk              always-on reference clock (same source as clk0)
//   rst_n            asynchronous active-low reset
//   req_valid        switch request valid
//   req_sel          requested source: 0 = clk0, 1 = clk1
//   req_ready        request can be accepted (IDLE only, low in reset)
//   pll_lock         PLL lock, asynchronous to clk
//   sel              registered select to the clock switch
//   busy             a request or fallback is in progress
//   done_pulse       one-cycle pulse when a request completes successfully
//   err_pulse        one-cycle pulse on lock timeout or aborted request
//   lock_lost_pulse  one-cycle pulse on automatic fallback to clk0
// -----------------------------------------------------------------------------
module clk_switch_ctrl #(
  parameter int unsigned LOCK_FILTER   = 8,
  parameter int unsigned LOCK_TIMEOUT  = 1024,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  input  logic pll_lock,
  output logic sel,
  output logic busy,
  output logic done_pulse,
  output logic err_pulse,
  output logic lock_lost_pulse
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOCK = 2'd1,
    SETTLE    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic             lock_meta;
  logic             lock_s;
  logic             started;
  logic             fallback;
  logic [CNT_W-1:0] lock_cnt;
  logic [CNT_W-1:0] tmo_cnt;
  logic [CNT_W-1:0] settle_cnt;
  logic             fall_now;
  logic             accept;

  // Two-flop synchronizer bringing the PLL lock into the reference domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // Keeps req_ready low while reset is asserted even though the state
  // register already reads IDLE; it rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started <= 1'b0;
    end else begin
      started <= 1'b1;
    end
  end

  // Loss of lock while clk1 is selected wins over everything else, including
  // a request presented in the same cycle.
  assign fall_now  = sel && !lock_s && (state != WAIT_LOCK);
  assign req_ready = started && (state == IDLE) && !fall_now;
  assign accept    = req_valid && req_ready;
  assign busy      = (state != IDLE);

  // Main sequencer. `fallback` marks a settle window that was started by lock
  // loss, so its completion returns to IDLE without a done_pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      sel             <= 1'b0;
      fallback        <= 1'b0;
      lock_cnt        <= '0;
      tmo_cnt         <= '0;
      settle_cnt      <= '0;
      done_pulse      <= 1'b0;
      err_pulse       <= 1'b0;
      lock_lost_pulse <= 1'b0;
    end else begin
      done_pulse      <= 1'b0;
      err_pulse       <= 1'b0;
      lock_lost_pulse <= 1'b0;
      if (fall_now) begin
        sel             <= 1'b0;
        lock_lost_pulse <= 1'b1;
        state           <= SETTLE;
        settle_cnt      <= '0;
        fallback        <= 1'b1;
        // A clk1 request still settling is abandoned and reported as an error.
        if (state == SETTLE) begin
          err_pulse <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              if (req_sel == sel) begin
                done_pulse <= 1'b1;
              end else if (!req_sel) begin
                sel        <= 1'b0;
                state      <= SETTLE;
                settle_cnt <= '0;
                fallback   <= 1'b0;
              end else begin
                state    <= WAIT_LOCK;
                lock_cnt <= '0;
                tmo_cnt  <= '0;
              end
            end
          end
          WAIT_LOCK: begin
            tmo_cnt  <= tmo_cnt + 1'b1;
            lock_cnt <= lock_s ? (lock_cnt + 1'b1) : '0;
            // Qualification is checked first so it beats a coincident timeout.
            if (lock_s && (lock_cnt == LOCK_LAST)) begin
              sel        <= 1'b1;
              state      <= SETTLE;
              settle_cnt <= '0;
              fallback   <= 1'b0;
            end else if (tmo_cnt == TMO_LAST) begin
              err_pulse <= 1'b1;
              state     <= IDLE;
            end
          end
          SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              state      <= IDLE;
              done_pulse <= !fallback;
              fallback   <= 1'b0;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_switch_ctrl
//
// Bench for clk_switch_ctrl. A driver issues directed and randomized requests
// and PLL lock waveforms. For every stimulus it plans the whole lock waveform
// up front, predicts the outcome from the timing rules (qualification after a
// run of consecutive synchronized lock-high cycles, timeout, settle window,
// fallback on lock loss) and pushes the expected pulse onto a scoreboard
// queue, plus per-cycle expectations for sel/busy/req_ready. A monitor on the
// falling edge pops the queue whenever a pulse appears and compares.
// -----------------------------------------------------------------------------
module tb_clk_switch_ctrl;

  localparam int LF   = 8;
  localparam int LT   = 64;
  localparam int SC   = 16;
  localparam int MAXC = 8192;

  localparam int EV_DONE    = 4;
  localparam int EV_ERR     = 2;
  localparam int EV_LOST    = 1;
  localparam int EV_ERRLOST = 3;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic req_valid;
  logic req_sel;
  logic req_ready;
  logic pll_lock;
  logic sel;
  logic busy;
  logic done_pulse;
  logic err_pulse;
  logic lock_lost_pulse;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  rel_cyc = 1;
  bit  m_sel = 1'b0;
  bit  sim_done = 1'b0;
  bit  pll_hist [MAXC];
  bit  exp_sel  [MAXC];
  bit  exp_busy [MAXC];
  bit  exp_ready[MAXC];
  ev_t sb[$];

  clk_switch_ctrl #(
    .LOCK_FILTER  (LF),
    .LOCK_TIMEOUT (LT),
    .SETTLE_CYCLES(SC),
    .CNT_W        (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_sel        (req_sel),
    .req_ready      (req_ready),
    .pll_lock       (pll_lock),
    .sel            (sel),
    .busy           (busy),
    .done_pulse     (done_pulse),
    .err_pulse      (err_pulse),
    .lock_lost_pulse(lock_lost_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic reportFail(string name, int detail);
    checks++;
    errors++;
    $display("[TB] FAIL %s at cycle %0d: pulse code %0d", name, cyc, detail);
  endtask

  task automatic fill_exp(int from, bit s, bit b, bit r);
    for (int c = from; c < MAXC; c++) begin
      exp_sel[c]   = s;
      exp_busy[c]  = b;
      exp_ready[c] = r;
    end
  endtask

  task automatic fill_pll(int from, bit v);
    for (int c = from; c < MAXC; c++) pll_hist[c] = v;
  endtask

  // Synchronized lock seen by the DUT in cycle c: the driven value two cycles
  // earlier, or 0 while the synchronizer is still coming out of reset.
  function automatic bit lock_s_at(int c);
    if (c - 2 >= rel_cyc) return pll_hist[c - 2];
    return 1'b0;
  endfunction

  task automatic push_ev(int kind, int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    pll_lock  = pll_hist[cyc];
  endtask

  // Issues one request in the current cycle, planning the lock waveform for
  // the given mode, and records the predicted outcome.
  task automatic applyStimulus(bit rs, int mode, output int end_cyc);
    int t;
    int q;
    int ab;
    int run;
    t = cyc;
    if (rs == m_sel) begin
      push_ev(EV_DONE, t + 1);
      fill_exp(t, m_sel, 1'b0, 1'b1);
      end_cyc = t + 1;
    end else if (!rs) begin
      fill_exp(t, 1'b1, 1'b0, 1'b1);
      fill_exp(t + 1, 1'b0, 1'b1, 1'b0);
      fill_exp(t + 1 + SC, 1'b0, 1'b0, 1'b1);
      push_ev(EV_DONE, t + 1 + SC);
      m_sel = 1'b0;
      end_cyc = t + 1 + SC;
    end else begin
      case (mode)
        0: fill_pll(t, 1'b1);
        1: fill_pll(t, 1'b0);
        2: begin
          fill_pll(t + 40, 1'b1);
          for (int k = 0; k < 40; k++) pll_hist[t + k] = (k % 5 == 4) ? 1'b0 : 1'b1;
        end
        3: begin
          fill_pll(t, 1'b1);
          for (int k = 0; k < 20; k++) pll_hist[t + k] = ($urandom_range(0, 9) != 0);
        end
        default: begin
          fill_pll(t, 1'b1);
          fill_pll(t + 9 + int'($urandom_range(0, 13)), 1'b0);
        end
      endcase
      pll_lock = pll_hist[t];
      run = 0;
      q = -1;
      for (int c = t + 1; c <= t + LT; c++) begin
        run = lock_s_at(c) ? run + 1 : 0;
        if (run == LF) begin
          q = c;
          break;
        end
      end
      fill_exp(t, 1'b0, 1'b0, 1'b1);
      fill_exp(t + 1, 1'b0, 1'b1, 1'b0);
      if (q < 0) begin
        push_ev(EV_ERR, t + LT + 1);
        fill_exp(t + LT + 1, 1'b0, 1'b0, 1'b1);
        end_cyc = t + LT + 1;
      end else begin
        fill_exp(q + 1, 1'b1, 1'b1, 1'b0);
        ab = -1;
        for (int c = q + 1; c <= q + SC; c++) begin
          if (!lock_s_at(c)) begin
            ab = c;
            break;
          end
        end
        if (ab < 0) begin
          push_ev(EV_DONE, q + 1 + SC);
          fill_exp(q + 1 + SC, 1'b1, 1'b0, 1'b1);
          m_sel = 1'b1;
          end_cyc = q + 1 + SC;
        end else begin
          push_ev(EV_ERRLOST, ab + 1);
          fill_exp(ab + 1, 1'b0, 1'b1, 1'b0);
          fill_exp(ab + 1 + SC, 1'b0, 1'b0, 1'b1);
          m_sel = 1'b0;
          end_cyc = ab + 1 + SC;
        end
      end
    end
    req_valid = 1'b1;
    req_sel   = rs;
  endtask

  // Drops the PLL lock while clk1 is selected and idle.
  task automatic dropLock(output int end_cyc);
    int p;
    int l;
    p = cyc + 1 + int'($urandom_range(0, 3));
    fill_pll(p, 1'b0);
    l = p;
    while (lock_s_at(l) && l < p + 4) l++;
    fill_exp(l, 1'b1, 1'b0, 1'b0);
    fill_exp(l + 1, 1'b0, 1'b1, 1'b0);
    fill_exp(l + 1 + SC, 1'b0, 1'b0, 1'b1);
    push_ev(EV_LOST, l + 1);
    m_sel = 1'b0;
    end_cyc = l + 1 + SC;
  endtask

  task automatic runTxn(int kind, int mode, int gap);
    int e;
    if (kind == 2) dropLock(e);
    else applyStimulus(kind[0], mode, e);
    while (cyc < e + gap) tick();
  endtask

  // Monitor: per-cycle level checks plus scoreboard pops on any pulse.
  always @(negedge clk) begin
    int obs;
    ev_t e;
    if (!sim_done && cyc < MAXC) begin
      checkOutput("sel", int'(sel), int'(exp_sel[cyc]));
      checkOutput("busy", int'(busy), int'(exp_busy[cyc]));
      checkOutput("req_ready", int'(req_ready), int'(exp_ready[cyc]));
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        reportFail("missing_pulse", e.kind);
      end
      obs = {29'd0, done_pulse, err_pulse, lock_lost_pulse};
      if (obs != 0) begin
        if (sb.size() == 0) begin
          reportFail("unexpected_pulse", obs);
        end else begin
          e = sb.pop_front();
          checkOutput("pulse_kind", obs, e.kind);
          checkOutput("pulse_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    int r;
    int k;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_sel   = 1'b0;
    fill_pll(0, 1'b1);
    pll_lock  = 1'b1;
    fill_exp(0, 1'b0, 1'b0, 1'b0);
    fill_exp(2, 1'b0, 1'b0, 1'b1);
    tick();
    rst_n   = 1'b1;
    rel_cyc = cyc;
    while (cyc < 10) tick();

    $display("[TB] directed scenarios");
    runTxn(1, 0, 2);
    runTxn(0, 0, 1);
    runTxn(0, 0, 0);
    runTxn(0, 0, 2);
    runTxn(1, 1, 2);
    runTxn(1, 2, 3);
    runTxn(2, 0, 2);
    runTxn(1, 4, 2);

    $display("[TB] randomized scenarios");
    for (int i = 0; i < 24 && cyc + 200 < MAXC; i++) begin
      r = int'($urandom_range(0, 2));
      if (m_sel) k = (r == 2) ? 2 : int'($urandom_range(0, 1));
      else k = (r == 0) ? 0 : 1;
      runTxn(k, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
    end

    $display("[TB] reset during clk1 settle");
    if (m_sel) runTxn(0, 0, 1);
    fill_pll(cyc, 1'b1);
    pll_lock = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    t = cyc;
    fill_exp(t, 1'b0, 1'b0, 1'b1);
    fill_exp(t + 1, 1'b0, 1'b1, 1'b0);
    fill_exp(t + 1 + LF, 1'b1, 1'b1, 1'b0);
    req_valid = 1'b1;
    req_sel   = 1'b1;
    while (cyc < t + LF + 6) tick();
    r = cyc;
    fill_exp(r, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_sel_drop", int'(sel), 0);
    checkOutput("reset_pulses", int'({done_pulse, err_pulse, lock_lost_pulse}), 0);
    m_sel = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst_n   = 1'b1;
    rel_cyc = cyc;
    fill_exp(cyc + 1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) tick();

    sim_done = 1'b1;
    while (sb.size() > 0) begin
      ev_t e;
      e = sb.pop_front();
      reportFail("pending_pulse", e.kind);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
